// File: rtl/msx_responder.sv
// MSX cartridge slot responder: bank-switched ROM reads with Z80 wait insertion,
// plus one read/write I/O port. All strobes are resynchronised into clk before use.
module msx_responder #(
    parameter logic [7:0] IO_PORT  = 8'h9E,
    parameter int         WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    inout  wire  [7:0]  data_bus,
    input  logic        rd,
    input  logic        wr,
    input  logic        iorq,
    input  logic        merq,
    input  logic        sltsl,
    output logic        nwait,
    output logic        busdir,
    output logic [20:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  io_wdata,
    output logic        io_wstb,
    input  logic [7:0]  io_rdata
);

    localparam int CNT_W = (WAIT_MAX > 15) ? $clog2(WAIT_MAX + 1) : 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRIVE,
        S_HOLD,
        S_TIMEOUT
    } state_t;

    // Strobe vector order: {rd, wr, iorq, merq, sltsl}
    logic [4:0]       sync1_q, sync1_d;
    logic [4:0]       sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             drive_q, drive_d;
    logic             nwait_q, nwait_d;
    logic             mem_rd_q, mem_rd_d;
    logic [20:0]      mem_addr_q, mem_addr_d;
    logic [7:0]       io_wdata_q, io_wdata_d;
    logic             io_wstb_q, io_wstb_d;
    logic [7:0]       bank_q [4];
    logic [7:0]       bank_d [4];

    logic rd_s, wr_s, iorq_s, merq_s, sltsl_s;
    logic rom_window, bank_window, io_hit;
    logic is_mrd, is_mwr, is_iord, is_iowr;
    logic [1:0] page;

    assign {rd_s, wr_s, iorq_s, merq_s, sltsl_s} = sync2_q;

    assign rom_window  = (address[15:14] == 2'b01) || (address[15:14] == 2'b10);
    assign bank_window = (address[15:13] == 3'b011);
    assign io_hit      = (address[7:0] == IO_PORT);
    // Pages 4000h/6000h/8000h/A000h map to banks 0..3
    assign page        = address[14:13] - 2'd2;

    assign is_mrd  = !sltsl_s && !merq_s && !rd_s && rom_window;
    assign is_mwr  = !sltsl_s && !merq_s && !wr_s;
    assign is_iord = !iorq_s && !rd_s && io_hit;
    assign is_iowr = !iorq_s && !wr_s && io_hit;

    always_comb begin
        sync1_d    = {rd, wr, iorq, merq, sltsl};
        sync2_d    = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        nwait_d    = nwait_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        io_wdata_d = io_wdata_q;
        io_wstb_d  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bank_d[i] = bank_q[i];
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (is_mrd) begin
                    state_d    = S_FETCH;
                    nwait_d    = 1'b0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {bank_q[page], address[12:0]};
                end else if (is_mwr) begin
                    state_d = S_HOLD;
                    if (bank_window) begin
                        bank_d[address[12:11]] = data_bus;
                    end
                end else if (is_iord) begin
                    state_d = S_DRIVE;
                    byte_d  = io_rdata;
                end else if (is_iowr) begin
                    state_d    = S_HOLD;
                    io_wdata_d = data_bus;
                    io_wstb_d  = 1'b1;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_d  = S_DRIVE;
                    byte_d   = mem_rdata;
                    mem_rd_d = 1'b0;
                    nwait_d  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    // ROM never answered: release the Z80 with open-bus data
                    state_d  = S_TIMEOUT;
                    byte_d   = 8'hFF;
                    mem_rd_d = 1'b0;
                    nwait_d  = 1'b1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TIMEOUT: begin
                state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (rd_s) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (wr_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        drive_d = (state_d == S_DRIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            byte_q     <= '0;
            drive_q    <= 1'b0;
            nwait_q    <= 1'b1;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            io_wdata_q <= '0;
            io_wstb_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= 8'(i);
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            drive_q    <= drive_d;
            nwait_q    <= nwait_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            io_wdata_q <= io_wdata_d;
            io_wstb_q  <= io_wstb_d;
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign data_bus = drive_q ? byte_q : 8'hzz;
    assign busdir   = ~drive_q;
    assign nwait    = nwait_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign io_wdata = io_wdata_q;
    assign io_wstb  = io_wstb_q;

endmodule

// File: tb/tb_msx_responder.sv
// Scoreboard bench for msx_responder: stimulus pushes expected ROM addresses, read bytes
// and I/O write bytes; an independent monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_msx_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        rd, wr, iorq, merq, sltsl;
    logic        nwait, busdir, mem_rd, io_wstb;
    logic [20:0] mem_addr;
    logic        resp_ack, stray_ack;
    wire         mem_ack;
    logic [7:0]  mem_rdata, io_wdata, io_rdata;
    wire  [7:0]  data_bus;
    logic        tb_drv_en;
    logic [7:0]  tb_drv;

    always #5 clk = ~clk;

    assign data_bus = tb_drv_en ? tb_drv : 8'hzz;
    assign mem_ack  = resp_ack | stray_ack;

    msx_responder #(.IO_PORT(8'h9E), .WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .address(address), .data_bus(data_bus),
        .rd(rd), .wr(wr), .iorq(iorq), .merq(merq), .sltsl(sltsl),
        .nwait(nwait), .busdir(busdir), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .io_wdata(io_wdata),
        .io_wstb(io_wstb), .io_rdata(io_rdata)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0]  exp_data_q[$];
    logic [20:0] exp_addr_q[$];
    logic [7:0]  exp_wdata_q[$];
    logic [7:0]  bank_m [4];
    bit          no_ack_mode = 1'b0;
    int          fixed_lat = -1;

    function automatic logic [7:0] rom_byte(input logic [20:0] a);
        return 8'(a ^ (a >> 13)) ^ 8'hA5;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Bus must read back whatever the bench drives; a stray DUT driver corrupts it.
    task automatic check_released(input string nm);
        logic [7:0] r1, r2;
        tb_drv = 8'h55; tb_drv_en = 1'b1; #1; r1 = data_bus;
        tb_drv = 8'hAA; #1; r2 = data_bus;
        tb_drv_en = 1'b0;
        check(nm, {16'h0, r1, r2}, 32'h000055AA);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) bank_m[i] = 8'(i);
    endtask

    task automatic expect_mrd(input logic [15:0] a);
        int pg;
        logic [20:0] ea;
        pg = (int'(a) - 'h4000) / 'h2000;
        ea = 21'(int'(bank_m[pg]) * 8192 + int'(a) % 8192);
        exp_addr_q.push_back(ea);
        exp_data_q.push_back(no_ack_mode ? 8'hFF : rom_byte(ea));
    endtask

    task automatic idle_bus();
        rd = 1'b1; wr = 1'b1; iorq = 1'b1; merq = 1'b1; sltsl = 1'b1;
    endtask

    task automatic do_read(input logic [15:0] a, input bit use_mem, input bit use_io,
                           input bit slt, input bit expect_resp, output int nw_low);
        int n;
        int bad;
        nw_low = 0;
        @(negedge clk);
        address = a; sltsl = slt; merq = !use_mem; iorq = !use_io; rd = 1'b0;
        if (expect_resp) begin
            n = 0;
            while (busdir !== 1'b0 && n < 80) begin
                @(negedge clk);
                n++;
                if (nwait === 1'b0) nw_low++;
            end
            check("read_drive_seen", {31'b0, busdir}, 32'd0);
            repeat (2) @(negedge clk);
            idle_bus();
            repeat (6) @(negedge clk);
            check("read_busdir_release", {31'b0, busdir}, 32'd1);
            check_released("read_bus_release");
        end else begin
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (busdir !== 1'b1 || mem_rd !== 1'b0 || nwait !== 1'b1) bad++;
            end
            check("no_response", bad, 0);
            idle_bus();
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            input bit use_mem, input bit use_io, input bit slt);
        @(negedge clk);
        address = a; tb_drv = d; tb_drv_en = 1'b1;
        sltsl = slt; merq = !use_mem; iorq = !use_io; wr = 1'b0;
        repeat (6) @(negedge clk);
        idle_bus();
        repeat (4) @(negedge clk);
        tb_drv_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ROM model: answers each mem_rd after a random (or fixed) latency
    initial begin
        int lat;
        resp_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1 && !no_ack_mode) begin
                lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 10));
                repeat (lat) @(negedge clk);
                resp_ack = 1'b1;
                mem_rdata = rom_byte(mem_addr);
                @(negedge clk);
                resp_ack = 1'b0;
                mem_rdata = 8'($urandom);
                while (mem_rd === 1'b1) @(negedge clk);
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a fetch, a bus drive or an I/O write
    logic prev_busdir = 1'b1;
    logic prev_mem_rd = 1'b0;
    int   wstb_len = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev_busdir = 1'b1; prev_mem_rd = 1'b0; wstb_len = 0;
            end else begin
                if (busdir === 1'b0 && prev_busdir === 1'b1) begin
                    if (exp_data_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_drive actual=%h required=no_drive", data_bus);
                    end else begin
                        check("read_data", {24'h0, data_bus}, {24'h0, exp_data_q.pop_front()});
                    end
                end
                if (mem_rd === 1'b1 && prev_mem_rd === 1'b0) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_mem_rd actual=%h required=no_fetch", mem_addr);
                    end else begin
                        check("mem_addr", {11'h0, mem_addr}, {11'h0, exp_addr_q.pop_front()});
                    end
                end
                if (io_wstb === 1'b1) begin
                    if (wstb_len == 0) begin
                        if (exp_wdata_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_io_wstb actual=%h required=no_strobe", io_wdata);
                        end else begin
                            check("io_wdata", {24'h0, io_wdata}, {24'h0, exp_wdata_q.pop_front()});
                        end
                    end
                    wstb_len++;
                end else if (wstb_len > 0) begin
                    check("io_wstb_width", wstb_len, 1);
                    wstb_len = 0;
                end
                prev_busdir = busdir;
                prev_mem_rd = mem_rd;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nw, n, lows, kind;
        logic [15:0] a;
        logic [7:0]  d;
        bit hit;

        idle_bus();
        address = 16'h0; tb_drv_en = 1'b0; tb_drv = 8'h00;
        io_rdata = 8'h00; stray_ack = 1'b0;
        reset = 1'b1;
        reset_model();
        repeat (3) @(negedge clk);
        check("rst_nwait", {31'b0, nwait}, 1);
        check("rst_busdir", {31'b0, busdir}, 1);
        check("rst_mem_rd", {31'b0, mem_rd}, 0);
        check("rst_mem_addr", {11'h0, mem_addr}, 0);
        check("rst_io_wdata", {24'h0, io_wdata}, 0);
        check("rst_io_wstb", {31'b0, io_wstb}, 0);
        check_released("rst_bus_z");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Bank write then banked read
        do_write(16'h7000, 8'h25, 1'b1, 1'b0, 1'b0);
        bank_m[2] = 8'h25;
        expect_mrd(16'h8123);
        do_read(16'h8123, 1'b1, 1'b0, 1'b0, 1'b1, nw);
        check("bank_example_addr", {11'h0, mem_addr}, 32'h0004A123);
        check("mrd_waited", {31'b0, nw > 0}, 1);

        // ROM never answers
        no_ack_mode = 1'b1;
        expect_mrd(16'h4000);
        do_read(16'h4000, 1'b1, 1'b0, 1'b0, 1'b1, nw);
        check("timeout_nwait_cycles", nw, 15);
        no_ack_mode = 1'b0;

        // I/O round trip and wrong port
        exp_wdata_q.push_back(8'h5A);
        do_write(16'h129E, 8'h5A, 1'b0, 1'b1, 1'b1);
        check("io_wdata_held", {24'h0, io_wdata}, 32'h5A);
        io_rdata = 8'hC3;
        exp_data_q.push_back(8'hC3);
        do_read(16'h009E, 1'b0, 1'b1, 1'b1, 1'b1, nw);
        check("iord_no_wait", nw, 0);
        do_read(16'h009F, 1'b0, 1'b1, 1'b1, 1'b0, nw);
        do_write(16'h009F, 8'h11, 1'b0, 1'b1, 1'b1);
        check("io_wdata_wrong_port", {24'h0, io_wdata}, 32'h5A);

        // Slot gating and address window
        do_read(16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, nw);
        do_read(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, nw);

        // Stray ack while idle
        @(negedge clk); stray_ack = 1'b1;
        @(negedge clk); stray_ack = 1'b0;
        lows = 0;
        repeat (4) begin
            @(negedge clk);
            if (busdir !== 1'b1 || mem_rd !== 1'b0 || nwait !== 1'b1) lows++;
        end
        check("stray_ack_ignored", lows, 0);

        // MRD and IORD together: memory wins
        io_rdata = 8'h77;
        expect_mrd(16'h409E);
        do_read(16'h409E, 1'b1, 1'b1, 1'b0, 1'b1, nw);

        // Z80 aborts the read during FETCH
        fixed_lat = 8;
        expect_mrd(16'hA010);
        @(negedge clk);
        address = 16'hA010; sltsl = 1'b0; merq = 1'b0; rd = 1'b0;
        n = 0;
        while (nwait !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        check("abort_nwait_low", {31'b0, nwait}, 0);
        idle_bus();
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (busdir === 1'b0) lows++;
        end
        check("abort_drive_cycles", lows, 1);
        check_released("abort_bus_release");
        fixed_lat = -1;

        // Randomised traffic
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 6));
            d = 8'($urandom);
            case (kind)
                0: begin
                    a = 16'h6000 + 16'($urandom_range(0, 16'h1FFF));
                    bank_m[(int'(a) - 'h6000) / 'h800] = d;
                    do_write(a, d, 1'b1, 1'b0, 1'b0);
                end
                1: begin
                    a = 16'($urandom);
                    if (a >= 16'h6000 && a < 16'h8000) a = a + 16'h8000;
                    do_write(a, d, 1'b1, 1'b0, 1'b0);
                end
                2, 3: begin
                    a = 16'h4000 + 16'($urandom_range(0, 16'h7FFF));
                    expect_mrd(a);
                    do_read(a, 1'b1, 1'b0, 1'b0, 1'b1, nw);
                end
                4: begin
                    hit = ($urandom_range(0, 3) != 0);
                    a = {8'($urandom), hit ? 8'h9E : (8'h9E ^ 8'($urandom_range(1, 255)))};
                    if (hit) exp_wdata_q.push_back(d);
                    do_write(a, d, 1'b0, 1'b1, 1'b1);
                end
                5: begin
                    hit = ($urandom_range(0, 3) != 0);
                    a = {8'($urandom), hit ? 8'h9E : (8'h9E ^ 8'($urandom_range(1, 255)))};
                    io_rdata = d;
                    if (hit) exp_data_q.push_back(d);
                    do_read(a, 1'b0, 1'b1, 1'b1, hit, nw);
                    if (hit) check("rand_iord_no_wait", nw, 0);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        a = 16'($urandom_range(0, 16'h3FFF));
                        if ($urandom_range(0, 1) == 0) a = a + 16'hC000;
                        do_read(a, 1'b1, 1'b0, 1'b0, 1'b0, nw);
                    end else begin
                        a = 16'h4000 + 16'($urandom_range(0, 16'h7FFF));
                        do_read(a, 1'b1, 1'b0, 1'b1, 1'b0, nw);
                    end
                end
            endcase
        end

        // Reset while the Z80 is held in FETCH
        no_ack_mode = 1'b1;
        do_write(16'h6800, 8'hE7, 1'b1, 1'b0, 1'b0);
        bank_m[1] = 8'hE7;
        exp_addr_q.push_back({bank_m[1], 13'h0042});
        @(negedge clk);
        address = 16'h6042; sltsl = 1'b0; merq = 1'b0; rd = 1'b0;
        n = 0;
        while (nwait !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        check("fetch_nwait_low", {31'b0, nwait}, 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_nwait", {31'b0, nwait}, 1);
        check("async_rst_mem_rd", {31'b0, mem_rd}, 0);
        check_released("async_rst_bus_fetch");
        idle_bus();
        no_ack_mode = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);

        // Reset while driving the bus
        io_rdata = 8'h3C;
        exp_data_q.push_back(8'h3C);
        @(negedge clk);
        address = 16'h009E; iorq = 1'b0; rd = 1'b0;
        n = 0;
        while (busdir !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        check("drive_before_reset", {31'b0, busdir}, 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busdir", {31'b0, busdir}, 1);
        check_released("async_rst_bus_drive");
        idle_bus();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Banks back to defaults on every page
        for (int p = 0; p < 4; p++) begin
            a = 16'(16'h4000 + p * 16'h2000 + 16'($urandom_range(0, 16'h1FFF)));
            expect_mrd(a);
            do_read(a, 1'b1, 1'b0, 1'b0, 1'b1, nw);
        end

        repeat (5) @(negedge clk);
        check("left_data_exp", exp_data_q.size(), 0);
        check("left_addr_exp", exp_addr_q.size(), 0);
        check("left_wdata_exp", exp_wdata_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
